// File: rtl/nco_phase_gen_if.sv
// Output sample stream of the NCO phase generator: valid/ready handshake
// carrying the range-reduced angle, its quadrant and the raw offset phase.
interface nco_phase_gen_if;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] angle_out;
   logic        [1:0]  quadrant_out;
   logic        [31:0] phase_out;

   modport master (
      output out_valid,
      output angle_out,
      output quadrant_out,
      output phase_out,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  angle_out,
      input  quadrant_out,
      input  phase_out,
      output out_ready
   );
endinterface

// File: rtl/nco_phase_gen.sv
// Phase accumulator followed by range reduction into a signed Q2.30 angle in
// [-pi/4, pi/4) plus quadrant, feeding the CORDIC core's convergence window.
module nco_phase_gen #(
   parameter logic [31:0] PI_HALF = 32'h6487ED51,
   parameter logic [31:0] EIGHTH  = 32'h20000000
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   fcw_load,
   input  logic [31:0]            fcw_in,
   input  logic [31:0]            phase_offset,
   input  logic                   phase_clear,
   nco_phase_gen_if.master        smp
);

   // Residual (turn units, +-2^29) times pi/2 in Q2.30, floored back to Q2.30.
   function automatic logic signed [31:0] scale_angle(input logic signed [30:0] resid);
      logic signed [62:0] resid_x;
      logic signed [62:0] k_x;
      logic signed [62:0] prod;
      resid_x = 63'(resid);
      k_x     = 63'($signed(PI_HALF));
      prod    = resid_x * k_x;
      return 32'(prod >>> 30);
   endfunction

   logic [31:0]        fcw_reg;
   logic [31:0]        acc;
   logic [31:0]        phase_p1;
   logic               vld_p1;
   logic [1:0]         quad_p2;
   logic signed [30:0] resid_p2;
   logic [31:0]        phase_p2;
   logic               vld_p2;
   logic signed [31:0] angle_p3;
   logic [1:0]         quad_p3;
   logic [31:0]        phase_p3;
   logic               vld_p3;

   logic               adv;
   logic [31:0]        shifted;
   logic signed [30:0] resid_next;

   assign adv        = !(vld_p3 && !smp.out_ready);
   assign shifted    = phase_p1 + EIGHTH;
   assign resid_next = $signed({1'b0, shifted[29:0]} - 31'h2000_0000);

   // Frequency word loads even while the pipeline is stalled.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         fcw_reg <= '0;
      end else if (fcw_load) begin
         fcw_reg <= fcw_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         phase_p1 <= '0;
         vld_p1   <= 1'b0;
         quad_p2  <= '0;
         resid_p2 <= '0;
         phase_p2 <= '0;
         vld_p2   <= 1'b0;
         angle_p3 <= '0;
         quad_p3  <= '0;
         phase_p3 <= '0;
         vld_p3   <= 1'b0;
      end else if (adv) begin
         // p0: accumulator, clear wins over enable
         if (phase_clear) begin
            acc <= '0;
         end else if (enable) begin
            acc <= acc + fcw_reg;
         end
         // p1: offset phase sampled from the pre-increment accumulator
         phase_p1 <= acc + phase_offset;
         vld_p1   <= enable && !phase_clear;
         // p2: quadrant split after shifting by an eighth turn
         quad_p2  <= shifted[31:30];
         resid_p2 <= resid_next;
         phase_p2 <= phase_p1;
         vld_p2   <= vld_p1 && !phase_clear;
         // p3: scale residual to radians
         angle_p3 <= scale_angle(resid_p2);
         quad_p3  <= quad_p2;
         phase_p3 <= phase_p2;
         vld_p3   <= vld_p2 && !phase_clear;
      end
   end

   assign smp.out_valid    = vld_p3;
   assign smp.angle_out    = angle_p3;
   assign smp.quadrant_out = quad_p3;
   assign smp.phase_out    = phase_p3;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen: static-phase vector table, scoreboarded sweep with
// backpressure, clear flush, enable bubbles and asynchronous reset.
module tb_nco_phase_gen;

   logic        clk_in;
   logic        rst_n;
   logic        enable;
   logic        fcw_load;
   logic [31:0] fcw_in;
   logic [31:0] phase_offset;
   logic        phase_clear;

   nco_phase_gen_if ifc ();

   nco_phase_gen dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .enable       (enable),
      .fcw_load     (fcw_load),
      .fcw_in       (fcw_in),
      .phase_offset (phase_offset),
      .phase_clear  (phase_clear),
      .smp          (ifc)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] phase;
      logic [1:0]  q;
      logic [31:0] angle;
   } exp_t;

   typedef struct {
      logic [31:0] off;
      logic [1:0]  q;
      logic [31:0] ang;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[8];
   logic [31:0] m_acc;
   logic [31:0] m_fcw;
   int          n_cmp;
   int          n_fail;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference range reduction done in 64-bit integer arithmetic.
   function automatic exp_t ref_of(input logic [31:0] ph);
      exp_t        e;
      logic [31:0] s;
      longint      r;
      longint      prod;
      s       = ph + 32'h2000_0000;
      r       = longint'({34'd0, s[29:0]}) - 64'sd536870912;
      prod    = r * 64'sd1686629713;
      e.phase = ph;
      e.q     = s[31:30];
      e.angle = 32'(prod >>> 30);
      return e;
   endfunction

   // One clock: update the model for the coming edge, then check what the DUT shows.
   task automatic cycle();
      logic adv;
      logic stall_vld;
      adv       = !(ifc.out_valid && !ifc.out_ready);
      stall_vld = ifc.out_valid && !ifc.out_ready;
      if (adv && ifc.out_valid && sb.size() > 0) void'(sb.pop_front());
      if (adv && phase_clear) begin
         sb.delete();
         m_acc = '0;
      end else if (adv && enable) begin
         sb.push_back(ref_of(m_acc + phase_offset));
         m_acc = m_acc + m_fcw;
      end
      if (fcw_load) m_fcw = fcw_in;
      @(posedge clk_in);
      #1;
      if (stall_vld) chk("stall_hold_valid", {95'd0, ifc.out_valid}, 96'd1);
      if (ifc.out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_valid", 96'd1, 96'd0);
         end else begin
            chk("sb_sample", {30'd0, ifc.quadrant_out, ifc.angle_out, ifc.phase_out},
                {30'd0, sb[0].q, sb[0].angle, sb[0].phase});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int waited;
   int n_xfer;

   initial begin
      tbl[0] = '{32'h0000_0000, 2'd0, 32'h0000_0000};
      tbl[1] = '{32'h1000_0000, 2'd0, 32'h1921_FB54};
      tbl[2] = '{32'h2000_0000, 2'd1, 32'hCDBC_0957};
      tbl[3] = '{32'h4000_0000, 2'd1, 32'h0000_0000};
      tbl[4] = '{32'hF000_0000, 2'd0, 32'hE6DE_04AB};
      tbl[5] = '{32'hE000_0000, 2'd0, 32'hCDBC_0957};
      tbl[6] = '{32'h1FFF_FFFF, 2'd0, 32'h3243_F6A6};
      tbl[7] = '{32'hC000_0000, 2'd3, 32'h0000_0000};

      n_cmp = 0; n_fail = 0; m_acc = '0; m_fcw = '0;
      rst_n = 1'b0; enable = 1'b0; fcw_load = 1'b0; fcw_in = '0;
      phase_offset = '0; phase_clear = 1'b0; ifc.out_ready = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("reset_outputs", {ifc.out_valid, ifc.quadrant_out, ifc.angle_out, ifc.phase_out}, 96'd0);
      rst_n = 1'b1;

      // Static phases with fcw = 0
      for (int i = 0; i < 8; i++) begin
         ifc.out_ready = 1'b1;
         phase_offset  = tbl[i].off;
         phase_clear   = 1'b1; enable = 1'b0; fcw_load = 1'b1; fcw_in = '0;
         cycle();
         phase_clear = 1'b0; fcw_load = 1'b0; enable = 1'b1;
         repeat (3) cycle();
         chk($sformatf("static_%0h", tbl[i].off),
             {29'd0, ifc.out_valid, ifc.quadrant_out, ifc.angle_out, ifc.phase_out},
             {29'd0, 1'b1, tbl[i].q, tbl[i].ang, tbl[i].off});
      end

      // Sweep with a 5-cycle backpressure window
      phase_offset = '0; phase_clear = 1'b1; enable = 1'b0;
      fcw_load = 1'b1; fcw_in = 32'h0100_0000;
      cycle();
      phase_clear = 1'b0; fcw_load = 1'b0; enable = 1'b1;
      n_xfer = 0;
      for (int c = 0; c < 300; c++) begin
         ifc.out_ready = !(c >= 100 && c < 105);
         if (ifc.out_valid && ifc.out_ready) begin
            chk($sformatf("sweep_phase_%0d", n_xfer), {64'd0, ifc.phase_out},
                {64'd0, 32'(n_xfer) * 32'h0100_0000});
            n_xfer++;
         end
         cycle();
      end
      chk("sweep_count_past_wrap", {95'd0, n_xfer >= 258}, 96'd1);

      // Clear mid-sweep flushes the pipeline
      ifc.out_ready = 1'b1;
      phase_clear = 1'b1;
      cycle();
      chk("clear_flush_0", {95'd0, ifc.out_valid}, 96'd0);
      phase_clear = 1'b0;
      cycle();
      chk("clear_flush_1", {95'd0, ifc.out_valid}, 96'd0);
      cycle();
      chk("clear_flush_2", {95'd0, ifc.out_valid}, 96'd0);
      cycle();
      chk("clear_first", {63'd0, ifc.out_valid, ifc.phase_out}, {63'd0, 1'b1, 32'h0});
      cycle();
      chk("clear_second", {63'd0, ifc.out_valid, ifc.phase_out}, {63'd0, 1'b1, 32'h0100_0000});

      // Enable bubbles: 1,0,1 then a later 1
      phase_clear = 1'b1; enable = 1'b0;
      cycle();
      phase_clear = 1'b0;
      for (int i = 0; i < 9; i++) begin
         enable = (i == 0 || i == 2 || i == 5);
         cycle();
         chk($sformatf("bubble_valid_%0d", i), {95'd0, ifc.out_valid},
             {95'd0, (i == 2 || i == 4 || i == 7)});
         if (i == 2) chk("bubble_phase_a", {64'd0, ifc.phase_out}, {64'd0, 32'h0000_0000});
         if (i == 4) chk("bubble_phase_b", {64'd0, ifc.phase_out}, {64'd0, 32'h0100_0000});
         if (i == 7) chk("bubble_phase_c", {64'd0, ifc.phase_out}, {64'd0, 32'h0200_0000});
      end

      // Asynchronous reset in the middle of a stream
      enable = 1'b1;
      repeat (6) cycle();
      @(posedge clk_in);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {ifc.out_valid, ifc.quadrant_out, ifc.angle_out, ifc.phase_out}, 96'd0);
      sb.delete(); m_acc = '0; m_fcw = '0;
      phase_offset = 32'h1234_5678; enable = 1'b1;
      @(posedge clk_in);
      #2;
      rst_n = 1'b1;
      waited = 0;
      while (!ifc.out_valid && waited < 10) begin
         cycle();
         waited++;
      end
      chk("reset_first_latency", {64'd0, 32'(waited)}, 96'd3);
      chk("reset_first_phase", {64'd0, ifc.phase_out}, {64'd0, 32'h1234_5678});

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
